// File: rtl/map_tile_renderer.sv
// Map tile renderer: loads one 40-tile map row per tile row during hblank, decodes tiles to RGB
// and counts remaining dots/pills per frame. Optional pill flashing enabled by PILL_FLASH_EN.
module map_tile_renderer (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [9:0]   x,
  input  logic [8:0]   y,
  output logic [4:0]   rdaddr,
  input  logic [159:0] rddata,
  output logic [7:0]   r,
  output logic [7:0]   g,
  output logic [7:0]   b,
  output logic [10:0]  items_left,
  output logic         frame_done
);

  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CAPT} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_armed;
  logic [4:0]     r_rdaddr;
  logic [159:0]   r_line_buf;
  logic [10:0]    r_accum;
  logic [10:0]    r_items;
  logic           r_frame_done;
  logic [23:0]    r_rgb;

  logic           w_trig, w_go, w_row0_capt, w_pill_on, w_active;
  logic [4:0]     w_next_row;
  logic [5:0]     w_cnt;
  logic [5:0]     w_col;
  logic [3:0]     w_px, w_py, w_nib;
  logic           w_in_dot, w_in_pill, w_in_body;
  logic [23:0]    w_rgb;

  function automatic logic in_rng(input logic [3:0] v, input logic [3:0] lo, input logic [3:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Trigger is a pure function of the current x/y so counter resyncs need no recovery.
  assign w_trig = r_armed && (x == 10'd640) &&
                  (((y[3:0] == 4'hF) && (y < 9'd479)) || (y == 9'd524));
  assign w_go        = w_trig && (r_state == S_IDLE);
  assign w_next_row  = (y == 9'd524) ? 5'd0 : (y[8:4] + 5'd1);
  assign w_row0_capt = (r_state == S_CAPT) && (r_rdaddr == 5'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Dots (1), pills (2) and ghosts standing on a dot/pill (6, 7) all count as items.
  always_comb begin
    w_cnt = 6'd0;
    for (int i = 0; i < 40; i++) begin
      if ((rddata[4*i +: 4] == 4'd1) || (rddata[4*i +: 4] == 4'd2) ||
          (rddata[4*i +: 4] == 4'd6) || (rddata[4*i +: 4] == 4'd7))
        w_cnt = w_cnt + 6'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_armed      <= 1'b1;
      r_rdaddr     <= 5'd0;
      r_line_buf   <= '0;
      r_accum      <= 11'd0;
      r_items      <= 11'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (x != 10'd640) r_armed <= 1'b1;
      else if (w_go)    r_armed <= 1'b0;
      if (w_go) r_rdaddr <= w_next_row;
      if (r_state == S_CAPT) begin
        r_line_buf <= rddata;
        if (w_row0_capt) begin
          r_items      <= r_accum;
          r_accum      <= {5'd0, w_cnt};
          r_frame_done <= 1'b1;
        end else begin
          r_accum <= r_accum + {5'd0, w_cnt};
        end
      end
    end
  end

`ifdef PILL_FLASH_EN
  logic [4:0] r_frame_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset)            r_frame_cnt <= 5'd0;
    else if (w_row0_capt) r_frame_cnt <= r_frame_cnt + 5'd1;
  end

  assign w_pill_on = ~r_frame_cnt[4];
`else
  assign w_pill_on = 1'b1;
`endif

  assign w_col    = x[9:4];
  assign w_px     = x[3:0];
  assign w_py     = y[3:0];
  assign w_active = (x < 10'd640) && (y < 9'd480);

  // Column 0 sits in the MSB nibble of the line buffer.
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < 40; i++) begin
      if (w_col == 6'(i)) w_nib = r_line_buf[(159 - 4*i) -: 4];
    end
  end

  assign w_in_dot  = in_rng(w_px, 4'd6, 4'd9)  && in_rng(w_py, 4'd6, 4'd9);
  assign w_in_pill = in_rng(w_px, 4'd4, 4'd11) && in_rng(w_py, 4'd4, 4'd11);
  assign w_in_body = in_rng(w_px, 4'd2, 4'd13) && in_rng(w_py, 4'd2, 4'd13);

  always_comb begin
    w_rgb = C_BLACK;
    if (w_active) begin
      case (w_nib)
        4'd0:    w_rgb = C_BLACK;
        4'd1:    if (w_in_dot) w_rgb = C_WHITE;
        4'd2:    if (w_in_pill && w_pill_on) w_rgb = C_WHITE;
        4'd3:    w_rgb = C_BLUE;
        4'd4:    if (w_in_body) w_rgb = C_YELLOW;
        4'd5, 4'd6, 4'd7: if (w_in_body) w_rgb = C_RED;
        default: w_rgb = C_MAGENTA;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_rgb <= C_BLACK;
    else       r_rgb <= w_rgb;
  end

  assign r          = r_rgb[23:16];
  assign g          = r_rgb[15:8];
  assign b          = r_rgb[7:0];
  assign rdaddr     = r_rdaddr;
  assign items_left = r_items;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed bench for map_tile_renderer: map RAM model, table-driven colour vectors and
// hand sequences for load timing, reset abort, item counting and pill flashing.
module tb_map_tile_renderer;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic [9:0]   x;
  logic [8:0]   y;
  logic [4:0]   rdaddr;
  logic [159:0] rddata;
  logic [7:0]   r, g, b;
  logic [10:0]  items_left;
  logic         frame_done;

  logic [159:0] mem [32];
  int n_cmp = 0;
  int n_bad = 0;
  int n_fd  = 0;

  typedef struct {
    int          row;
    int          xv;
    int          yv;
    logic [23:0] exp;
  } vec_t;

  vec_t tv[$];

  map_tile_renderer dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .rdaddr    (rdaddr),
    .rddata    (rddata),
    .r         (r),
    .g         (g),
    .b         (b),
    .items_left(items_left),
    .frame_done(frame_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) rddata <= mem[rdaddr];

  always @(negedge CLOCK_50) if (frame_done === 1'b1) n_fd++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_nib(input int row, input int col, input logic [3:0] v);
    mem[row][(159 - 4*col) -: 4] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1; x = 10'd100; y = 9'd100;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  // Present the trigger for 'hold' clocks, then leave x off 640 long enough to finish the load.
  task automatic do_load(input int row, input int hold);
    @(negedge CLOCK_50);
    y = (row == 0) ? 9'd524 : 9'(16*row - 1);
    x = 10'd640;
    repeat (hold) @(negedge CLOCK_50);
    x = 10'd641;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic render(input string name, input int xv, input int yv, input logic [23:0] exp);
    @(negedge CLOCK_50);
    x = 10'(xv); y = 9'(yv);
    @(negedge CLOCK_50);
    chk(name, {8'd0, r, g, b}, {8'd0, exp});
  endtask

  initial begin
    int last_row;
    reset = 1'b1; x = 10'd100; y = 9'd100;
    clear_mem();
    for (int c = 0; c < 40; c++) set_nib(3, c, 4'd3);
    set_nib(0, 0, 4'd4);  set_nib(0, 1, 4'd1);  set_nib(0, 2, 4'd2);
    set_nib(0, 3, 4'd5);  set_nib(0, 4, 4'd7);  set_nib(0, 5, 4'd8);
    set_nib(0, 39, 4'd3);
    set_nib(5, 2, 4'd6);
    set_nib(7, 0, 4'd15);

    // Reset state
    do_reset();
    @(negedge CLOCK_50);
    chk("rst_rgb", {8'd0, r, g, b}, 32'h0);
    chk("rst_items", 32'(items_left), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_rdaddr", 32'(rdaddr), 32'd0);
    render("rst_row0_black", 8, 8, 24'h000000);

    // Row 3 load timing: rdaddr one clock after trigger, line_buf the clock after
    @(negedge CLOCK_50);
    y = 9'd47; x = 10'd640;
    @(posedge CLOCK_50);
    #1 chk("trig_rdaddr", 32'(rdaddr), 32'd3);
    @(negedge CLOCK_50);
    x = 10'd641;
    @(negedge CLOCK_50);
    render("row3_wall", 16, 48, 24'h0000FF);

    tv.push_back('{3, 639, 63,  24'h0000FF});
    tv.push_back('{3, 640, 48,  24'h000000});
    tv.push_back('{3, 16,  480, 24'h000000});
    tv.push_back('{0, 8,   8,   24'hFFFF00});
    tv.push_back('{0, 24,  8,   24'hFFFFFF});
    tv.push_back('{0, 16,  8,   24'h000000});
    tv.push_back('{0, 22,  6,   24'hFFFFFF});
    tv.push_back('{0, 21,  8,   24'h000000});
    tv.push_back('{0, 25,  9,   24'hFFFFFF});
    tv.push_back('{0, 26,  8,   24'h000000});
    tv.push_back('{0, 2,   2,   24'hFFFF00});
    tv.push_back('{0, 1,   8,   24'h000000});
    tv.push_back('{0, 13,  13,  24'hFFFF00});
    tv.push_back('{0, 14,  8,   24'h000000});
    tv.push_back('{0, 36,  4,   24'hFFFFFF});
    tv.push_back('{0, 35,  8,   24'h000000});
    tv.push_back('{0, 43,  11,  24'hFFFFFF});
    tv.push_back('{0, 44,  8,   24'h000000});
    tv.push_back('{0, 50,  2,   24'hFF0000});
    tv.push_back('{0, 49,  8,   24'h000000});
    tv.push_back('{0, 72,  8,   24'hFF0000});
    tv.push_back('{0, 80,  0,   24'hFF00FF});
    tv.push_back('{0, 100, 8,   24'h000000});
    tv.push_back('{0, 639, 479, 24'h0000FF});
    tv.push_back('{5, 40,  88,  24'hFF0000});
    tv.push_back('{5, 700, 88,  24'h000000});
    tv.push_back('{7, 0,   112, 24'hFF00FF});
    tv.push_back('{7, 15,  127, 24'hFF00FF});

    last_row = 3;
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].row != last_row) begin
        do_load(tv[i].row, 2);
        last_row = tv[i].row;
      end
      render($sformatf("vec%0d", i), tv[i].xv, tv[i].yv, tv[i].exp);
    end

    // Reset between ADDR and CAPT must abandon the load
    @(negedge CLOCK_50);
    y = 9'd47; x = 10'd640;
    @(negedge CLOCK_50);
    reset = 1'b1; x = 10'd641;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("abort_rdaddr", 32'(rdaddr), 32'd0);
    repeat (3) @(negedge CLOCK_50);
    render("abort_linebuf", 16, 48, 24'h000000);

    // Item counting over two frames; x held on 640 for 4 clocks to exercise the armed flag
    clear_mem();
    for (int c = 0; c < 10; c++) begin
      set_nib(0, c, 4'd1); set_nib(10, c, 4'd2); set_nib(20, c, 4'd6);
    end
    for (int c = 0; c < 7; c++) set_nib(29, c, 4'd7);
    for (int c = 0; c < 40; c++) begin
      set_nib(15, c, 4'd3); set_nib(30, c, 4'd1); set_nib(31, c, 4'd2);
    end
    do_reset();
    n_fd = 0;
    do_load(0, 4);
    chk("frame1_items", 32'(items_left), 32'd0);
    chk("frame1_pulses", 32'(n_fd), 32'd1);
    for (int row = 1; row < 30; row++) do_load(row, 4);
    chk("last_row_rdaddr", 32'(rdaddr), 32'd29);
    @(negedge CLOCK_50);
    y = 9'd479; x = 10'd640;
    repeat (2) @(negedge CLOCK_50);
    x = 10'd641;
    repeat (2) @(negedge CLOCK_50);
    chk("y479_no_load", 32'(rdaddr), 32'd29);
    y = 9'd495; x = 10'd640;
    repeat (2) @(negedge CLOCK_50);
    x = 10'd641;
    repeat (2) @(negedge CLOCK_50);
    chk("y495_no_load", 32'(rdaddr), 32'd29);
    do_load(0, 4);
    chk("frame2_items", 32'(items_left), 32'd37);
    chk("frame2_pulses", 32'(n_fd), 32'd2);

`ifdef PILL_FLASH_EN
    clear_mem();
    set_nib(0, 2, 4'd2);
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      do_load(0, 2);
      render($sformatf("flash_k%0d", k), 40, 8, ((k % 32) < 16) ? 24'hFFFFFF : 24'h000000);
      if (k == 2) chk("flash_items", 32'(items_left), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
